ps2_command_parser: RTL
=======================

Name: ps2_command_parser

Overview:
- Sits directly downstream of ps2_cleaner and consumes its ASCII character strobe.
- Assembles typed characters into a 32-character line buffer, with backspace editing.
- On Enter, publishes the committed line to display_controller and decodes velocity/angle commands for the trajectory processor (velocity feeds reg29; angle feeds angle_to_trig).

Parameters:
MAX_CHARS, 32, line buffer depth in characters; line bus width is 8*MAX_CHARS.
MAX_VELOCITY, 999, largest accepted velocity value.
MAX_ANGLE, 90, largest accepted angle value in degrees.
INIT_VELOCITY, 0, velocity output value after reset.
INIT_ANGLE, 45, angle output value after reset.

Ports:
clock  input  1  system clock; all logic is on the rising edge.
resetn  input  1  asynchronous active-low reset.
char_in  input  8  ASCII character from ps2_cleaner.
char_valid  input  1  one-cycle strobe; char_in is valid while this is high.
busy  output  1  high while the parser is in PARSE or DONE.
line_content  output  256  last committed line; char i occupies bits [8i+7:8i]; unused bytes are 0x00.
line_ready  output  1  one-cycle pulse when line_content updates.
velocity  output  32  last accepted velocity.
angle  output  32  last accepted angle.
cmd_done  output  1  one-cycle pulse when a command is accepted.
cmd_error  output  1  one-cycle pulse when a non-empty line is rejected.
overflow  output  1  sticky flag; set when a character is dropped because the buffer is full.

Behaviour:
- Reset (asynchronous, resetn=0):
  - Edit buffer, line_content and all pulses are cleared; overflow=0.
  - velocity=INIT_VELOCITY, angle=INIT_ANGLE.
  - State returns to COLLECT; a parse in progress is abandoned with no output change.
- States: COLLECT, PARSE, DONE.
- COLLECT:
  - Printable character (0x20-0x7E): written at index len, len increments. If len==MAX_CHARS, the character is dropped and overflow is set.
  - 0x08 (backspace): if len>0, len decrements and that byte clears to 0x00. If len==0, no effect.
  - 0x0D or 0x0A (Enter) accepted in cycle N:
    - Cycle N+1: line_content takes the edit buffer, line_ready pulses, the edit buffer clears, len goes to 0, and overflow clears.
    - If the committed length is 0: return to COLLECT with no cmd pulse. Otherwise go to PARSE with idx=0.
  - Any other code is ignored.
- PARSE: processes committed byte idx each cycle.
  - Grammar: letter ('V'/'v' or 'A'/'a'), then zero or more spaces, then one or more digits, then zero or more trailing spaces.
  - Accumulator: acc = acc*10 + digit, 32-bit. It saturates at 32'hFFFF_FFFF and sets a sat flag.
  - When idx reaches the committed length, go to DONE. A grammar violation sets an err flag; parsing continues to the end so latency is fixed.
- DONE (single cycle):
  - Rejected if err is set, no digits were seen, sat is set, the value exceeds MAX_VELOCITY (V) or MAX_ANGLE (A), or the leading letter is unknown.
  - Accepted: the target register updates and cmd_done pulses.
  - Rejected: cmd_error pulses and both registers are unchanged.
  - Then return to COLLECT.
- Latency: with Enter in cycle N and committed length L>0, velocity/angle and cmd_done appear at N+L+2.
- busy=1 throughout PARSE and DONE; characters arriving then are dropped and do not set overflow.
- Enter with a full buffer is still accepted.
- cmd_done and cmd_error are never high in the same cycle.

Optional Feature:
- Macro: PS2CMD_FIRE_EN.
- When defined: adds output port fire (1 bit). A line 'F'/'f' followed only by spaces pulses fire and cmd_done in DONE; velocity and angle are unchanged.
- When undefined: no fire port, and a leading 'F' is an unknown letter and produces cmd_error.

Decomposition:
- Package ps2_cmd_pkg: ASCII constants (BS=0x08, CR=0x0D, LF=0x0A, SPACE, '0', 'V', 'v', 'A', 'a', 'F', 'f'), the state encoding, and the parse sub-state encoding (LETTER, PRE_SP, DIGITS, POST_SP).
- Sub-module ps2_decimal_accum: combinational multiply-by-10-plus-digit with saturation detect, instantiated once inside the parser.

Test Plan:
- Type "V120", then Enter: line_ready 1 cycle after Enter, line_content[31:0]=0x30323156, velocity=120 and cmd_done at Enter+6; angle stays 45.
- Type "a 9X", Enter, then "A91", Enter: first line gives cmd_error, second gives cmd_error (91 > MAX_ANGLE); angle remains 45.
- Type "V5", backspace, "7", Enter: velocity=7. Backspace on an empty buffer: len stays 0, no pulse.
- Type 33 chars "V" + 32×"1": overflow=1 and the 33rd char is dropped; Enter gives cmd_error (value > 999) and overflow clears.
- Strobe chars during busy, and assert resetn=0 mid-PARSE: dropped chars do not appear in the buffer; after reset velocity=0, angle=45, no cmd pulse.
- With PS2CMD_FIRE_EN defined, "f  " then Enter: fire and cmd_done pulse together. Without the macro, the same input gives cmd_error.

Source files
------------

// File: rtl/ps2_cmd_pkg.sv
// ps2_cmd_pkg: shared constants and encodings for the PS/2 command parser.
//   - ASCII codes for the editing keys, digits and command letters
//   - top-level FSM state, parse sub-state and command kind encodings
//   - small character-class helpers
package ps2_cmd_pkg;

    localparam logic [7:0] ASCII_BS    = 8'h08;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_9     = 8'h39;
    localparam logic [7:0] ASCII_V_UP  = 8'h56;
    localparam logic [7:0] ASCII_V_LO  = 8'h76;
    localparam logic [7:0] ASCII_A_UP  = 8'h41;
    localparam logic [7:0] ASCII_A_LO  = 8'h61;
    localparam logic [7:0] ASCII_F_UP  = 8'h46;
    localparam logic [7:0] ASCII_F_LO  = 8'h66;
    localparam logic [7:0] ASCII_TILDE = 8'h7E;

    typedef enum logic [1:0] {StCollect, StParse, StDone} state_e;

    typedef enum logic [1:0] {SubLetter, SubPreSp, SubDigits, SubPostSp} parse_sub_e;

    typedef enum logic [1:0] {KindNone, KindVel, KindAng, KindFire} cmd_kind_e;

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= ASCII_0) && (c <= ASCII_9);
    endfunction

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= ASCII_SPACE) && (c <= ASCII_TILDE);
    endfunction

endpackage

// File: rtl/ps2_decimal_accum.sv
// ps2_decimal_accum: combinational acc*10 + digit with saturation.
//   acc    in  32  running value
//   digit  in   4  decimal digit 0..9
//   result out 32  next value, clamped to 32'hFFFF_FFFF
//   sat    out  1  high when the true result does not fit in 32 bits
module ps2_decimal_accum (
    input  logic [31:0] acc,
    input  logic [3:0]  digit,
    output logic [31:0] result,
    output logic        sat
);
    logic [35:0] wide;

    // (acc << 3) + (acc << 1) == acc * 10; max value fits in 36 bits
    assign wide   = ({4'b0, acc} << 3) + ({4'b0, acc} << 1) + {32'b0, digit};
    assign sat    = |wide[35:32];
    assign result = sat ? 32'hFFFF_FFFF : wide[31:0];

endmodule

// File: rtl/ps2_command_parser.sv
// ps2_command_parser: line editor and velocity/angle command decoder fed by ps2_cleaner.
//   clock, resetn    clock and asynchronous active-low reset
//   char_in/valid    ASCII character strobe
//   busy             high while parsing or finishing a committed line
//   line_content     last committed line, char i in bits [8i+7:8i], unused bytes zero
//   line_ready       one-cycle pulse when line_content updates
//   velocity, angle  last accepted values
//   cmd_done/error   one-cycle accept / reject pulses
//   overflow         sticky; a character was dropped on a full buffer (cleared by Enter)
//   fire             only with PS2CMD_FIRE_EN defined: pulses on an accepted 'F' line
module ps2_command_parser
    import ps2_cmd_pkg::*;
#(
    parameter int unsigned MAX_CHARS     = 32,
    parameter int unsigned MAX_VELOCITY  = 999,
    parameter int unsigned MAX_ANGLE     = 90,
    parameter int unsigned INIT_VELOCITY = 0,
    parameter int unsigned INIT_ANGLE    = 45
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic [7:0]             char_in,
    input  logic                   char_valid,
    output logic                   busy,
    output logic [8*MAX_CHARS-1:0] line_content,
    output logic                   line_ready,
    output logic [31:0]            velocity,
    output logic [31:0]            angle,
    output logic                   cmd_done,
    output logic                   cmd_error,
    output logic                   overflow
`ifdef PS2CMD_FIRE_EN
    ,
    output logic                   fire
`endif
);
    localparam int unsigned LW = $clog2(MAX_CHARS + 1);  // holds 0..MAX_CHARS
    localparam int unsigned IW = $clog2(MAX_CHARS);      // indexes a byte

    state_e                      state_q, state_d;
    parse_sub_e                  psub_q, psub_d;
    cmd_kind_e                   kind_q, kind_d;
    logic [MAX_CHARS-1:0][7:0]   edit_q, edit_d;
    logic [MAX_CHARS-1:0][7:0]   line_q, line_d;
    logic [LW-1:0]               len_q, len_d, clen_q, clen_d, idx_q, idx_d, len_m1;
    logic [31:0]                 acc_q, acc_d, vel_q, vel_d, ang_q, ang_d;
    logic                        sat_q, sat_d, err_q, err_d, dig_q, dig_d;
    logic                        ready_q, ready_d, done_q, done_d, error_q, error_d;
    logic                        ovf_q, ovf_d, accept;
    logic [7:0]                  cur_ch;
    logic [31:0]                 acc_next;
    logic                        acc_sat;

    assign len_m1 = len_q - LW'(1);
    assign cur_ch = line_q[idx_q[IW-1:0]];

    ps2_decimal_accum u_accum (
        .acc    (acc_q),
        .digit  (cur_ch[3:0]),
        .result (acc_next),
        .sat    (acc_sat)
    );

`ifdef PS2CMD_FIRE_EN
    logic fire_q, fire_d;
    assign fire = fire_q;
`endif

    always_comb begin
        state_d = state_q;
        psub_d  = psub_q;
        kind_d  = kind_q;
        edit_d  = edit_q;
        line_d  = line_q;
        len_d   = len_q;
        clen_d  = clen_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        vel_d   = vel_q;
        ang_d   = ang_q;
        sat_d   = sat_q;
        err_d   = err_q;
        dig_d   = dig_q;
        ovf_d   = ovf_q;
        ready_d = 1'b0;
        done_d  = 1'b0;
        error_d = 1'b0;
        accept  = 1'b0;
`ifdef PS2CMD_FIRE_EN
        fire_d  = 1'b0;
`endif
        unique case (state_q)
            StCollect: begin
                if (char_valid) begin
                    if (is_printable(char_in)) begin
                        if (len_q == LW'(MAX_CHARS)) begin
                            ovf_d = 1'b1;
                        end else begin
                            edit_d[len_q[IW-1:0]] = char_in;
                            len_d = len_q + LW'(1);
                        end
                    end else if (char_in == ASCII_BS) begin
                        if (len_q != '0) begin
                            edit_d[len_m1[IW-1:0]] = 8'h00;
                            len_d = len_m1;
                        end
                    end else if ((char_in == ASCII_CR) || (char_in == ASCII_LF)) begin
                        line_d  = edit_q;
                        clen_d  = len_q;
                        ready_d = 1'b1;
                        edit_d  = '0;
                        len_d   = '0;
                        ovf_d   = 1'b0;
                        idx_d   = '0;
                        psub_d  = SubLetter;
                        kind_d  = KindNone;
                        acc_d   = '0;
                        sat_d   = 1'b0;
                        err_d   = 1'b0;
                        dig_d   = 1'b0;
                        if (len_q != '0) state_d = StParse;
                    end
                end
            end
            StParse: begin
                unique case (psub_q)
                    SubLetter: begin
                        if ((cur_ch == ASCII_V_UP) || (cur_ch == ASCII_V_LO)) begin
                            kind_d = KindVel;
                        end else if ((cur_ch == ASCII_A_UP) || (cur_ch == ASCII_A_LO)) begin
                            kind_d = KindAng;
`ifdef PS2CMD_FIRE_EN
                        end else if ((cur_ch == ASCII_F_UP) || (cur_ch == ASCII_F_LO)) begin
                            kind_d = KindFire;
`endif
                        end else begin
                            kind_d = KindNone;
                        end
                        psub_d = SubPreSp;
                    end
                    SubPreSp, SubDigits: begin
                        if (is_digit(cur_ch)) begin
                            acc_d  = acc_next;
                            sat_d  = sat_q | acc_sat;
                            dig_d  = 1'b1;
                            psub_d = SubDigits;
                        end else if (cur_ch == ASCII_SPACE) begin
                            if (psub_q == SubDigits) psub_d = SubPostSp;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    SubPostSp: begin
                        if (cur_ch != ASCII_SPACE) err_d = 1'b1;
                    end
                endcase
                // keep walking after an error so the latency does not depend on content
                idx_d = idx_q + LW'(1);
                if (idx_d == clen_q) state_d = StDone;
            end
            StDone: begin
                unique case (kind_q)
                    KindVel: begin
                        accept = !err_q && dig_q && !sat_q && (acc_q <= 32'(MAX_VELOCITY));
                        if (accept) vel_d = acc_q;
                    end
                    KindAng: begin
                        accept = !err_q && dig_q && !sat_q && (acc_q <= 32'(MAX_ANGLE));
                        if (accept) ang_d = acc_q;
                    end
`ifdef PS2CMD_FIRE_EN
                    KindFire: begin
                        accept = !err_q && !dig_q;
                        fire_d = accept;
                    end
`endif
                    default: accept = 1'b0;
                endcase
                done_d  = accept;
                error_d = !accept;
                state_d = StCollect;
            end
            default: state_d = StCollect;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= StCollect;
            psub_q  <= SubLetter;
            kind_q  <= KindNone;
            edit_q  <= '0;
            line_q  <= '0;
            len_q   <= '0;
            clen_q  <= '0;
            idx_q   <= '0;
            acc_q   <= '0;
            vel_q   <= 32'(INIT_VELOCITY);
            ang_q   <= 32'(INIT_ANGLE);
            sat_q   <= 1'b0;
            err_q   <= 1'b0;
            dig_q   <= 1'b0;
            ovf_q   <= 1'b0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
`ifdef PS2CMD_FIRE_EN
            fire_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            psub_q  <= psub_d;
            kind_q  <= kind_d;
            edit_q  <= edit_d;
            line_q  <= line_d;
            len_q   <= len_d;
            clen_q  <= clen_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            vel_q   <= vel_d;
            ang_q   <= ang_d;
            sat_q   <= sat_d;
            err_q   <= err_d;
            dig_q   <= dig_d;
            ovf_q   <= ovf_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            error_q <= error_d;
`ifdef PS2CMD_FIRE_EN
            fire_q  <= fire_d;
`endif
        end
    end

    assign busy         = (state_q == StParse) || (state_q == StDone);
    assign line_content = line_q;
    assign line_ready   = ready_q;
    assign velocity     = vel_q;
    assign angle        = ang_q;
    assign cmd_done     = done_q;
    assign cmd_error    = error_q;
    assign overflow     = ovf_q;

endmodule
